// File: rtl/ram_dp_sr_sw_be.sv
// rtl/ram_dp_sr_sw_be.sv - true dual-port RAM with byte enables, registered read-first outputs, collision counter
// Optional macro RAM_DP_OUTREG_EN adds an output register stage (read latency 2).
module ram_dp_sr_sw_be #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 8,
    parameter  int RAM_DEPTH  = 1 << ADDR_WIDTH,
    localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  cs_0,
    input  logic                  we_0,
    input  logic [BE_WIDTH-1:0]   be_0,
    input  logic [ADDR_WIDTH-1:0] address_0,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    output logic [DATA_WIDTH-1:0] rdata_0,
    output logic                  rvalid_0,
    input  logic                  cs_1,
    input  logic                  we_1,
    input  logic [BE_WIDTH-1:0]   be_1,
    input  logic [ADDR_WIDTH-1:0] address_1,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic [DATA_WIDTH-1:0] rdata_1,
    output logic                  rvalid_1,
    output logic                  collision,
    output logic [15:0]           coll_cnt
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic in_range_0, in_range_1;
    logic wr_0, wr_1, rd_0, rd_1;
    logic coll_det;

    logic [DATA_WIDTH-1:0] rdata_0_d, rdata_0_q, rdata_1_d, rdata_1_q;
    logic                  rvalid_0_q, rvalid_1_q;
    logic                  coll_q;
    logic [15:0]           coll_cnt_d, coll_cnt_q;
    logic                  coll_inc;

    always_comb begin
        in_range_0 = ({1'b0, address_0} < DEPTH_W);
        in_range_1 = ({1'b0, address_1} < DEPTH_W);
        wr_0       = cs_0 & we_0 & in_range_0;
        wr_1       = cs_1 & we_1 & in_range_1;
        rd_0       = cs_0 & ~we_0;
        rd_1       = cs_1 & ~we_1;
        coll_det   = cs_0 & cs_1 & (address_0 == address_1) & (we_0 | we_1);
    end

    // Port 1 is written first so port 0 overrides bytes enabled on both ports.
    always_ff @(posedge sys_clk) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
            if (wr_1 && be_1[b]) mem[address_1][b*8 +: 8] <= wdata_1[b*8 +: 8];
            if (wr_0 && be_0[b]) mem[address_0][b*8 +: 8] <= wdata_0[b*8 +: 8];
        end
    end

    // Read data is taken before this edge's writes land, giving read-first collisions.
    always_comb begin
        rdata_0_d = rdata_0_q;
        rdata_1_d = rdata_1_q;
        if (rd_0) rdata_0_d = in_range_0 ? mem[address_0] : '0;
        if (rd_1) rdata_1_d = in_range_1 ? mem[address_1] : '0;
    end

    always_comb begin
        coll_cnt_d = coll_cnt_q;
        if (coll_inc && (coll_cnt_q != 16'hFFFF)) coll_cnt_d = coll_cnt_q + 16'd1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rdata_0_q  <= '0;
            rdata_1_q  <= '0;
            rvalid_0_q <= 1'b0;
            rvalid_1_q <= 1'b0;
            coll_q     <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            rdata_0_q  <= rdata_0_d;
            rdata_1_q  <= rdata_1_d;
            rvalid_0_q <= rd_0;
            rvalid_1_q <= rd_1;
            coll_q     <= coll_det;
            coll_cnt_q <= coll_cnt_d;
        end
    end

`ifdef RAM_DP_OUTREG_EN
    logic [DATA_WIDTH-1:0] rdata_0_q2, rdata_1_q2;
    logic                  rvalid_0_q2, rvalid_1_q2;
    logic                  coll_q2;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rdata_0_q2  <= '0;
            rdata_1_q2  <= '0;
            rvalid_0_q2 <= 1'b0;
            rvalid_1_q2 <= 1'b0;
            coll_q2     <= 1'b0;
        end else begin
            rdata_0_q2  <= rdata_0_q;
            rdata_1_q2  <= rdata_1_q;
            rvalid_0_q2 <= rvalid_0_q;
            rvalid_1_q2 <= rvalid_1_q;
            coll_q2     <= coll_q;
        end
    end

    // Counter advances on the same edge the delayed pulse becomes visible.
    assign coll_inc  = coll_q;
    assign rdata_0   = rdata_0_q2;
    assign rdata_1   = rdata_1_q2;
    assign rvalid_0  = rvalid_0_q2;
    assign rvalid_1  = rvalid_1_q2;
    assign collision = coll_q2;
`else
    assign coll_inc  = coll_det;
    assign rdata_0   = rdata_0_q;
    assign rdata_1   = rdata_1_q;
    assign rvalid_0  = rvalid_0_q;
    assign rvalid_1  = rvalid_1_q;
    assign collision = coll_q;
`endif

    assign coll_cnt = coll_cnt_q;

endmodule
